rv_alu: RTL and testbench

- Integer ALU for the RV32I core; executes the R/I-type arithmetic and logic ops plus the compare ops used by branch resolution.
- Operands x/y arrive from the register/immediate mux; result and zero flag are registered (one-cycle latency) and feed write-back, store address and branch decision.
- Pure datapath: no memory access, no state beyond the output registers.

---
 rtl/rv_pkg.sv | 38 +++
 rtl/rv_alu_if.sv | 15 +
 rtl/rv_alu_shifter.sv | 22 ++
 rtl/rv_alu.sv | 67 ++++++
 tb/tb_rv_alu.sv | 126 ++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: ALU function codes and base opcode constants.
// Imported by the ALU and by the rest of the core.
package rv_pkg;

  // ALU fn = {alt, funct3}; alt only distinguishes ADD/SUB and SRL/SRA
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SUB  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd13;

  typedef enum logic [2:0] {
    F3_ADD  = 3'd0,
    F3_SLL  = 3'd1,
    F3_SLT  = 3'd2,
    F3_SLTU = 3'd3,
    F3_XOR  = 3'd4,
    F3_SR   = 3'd5,
    F3_OR   = 3'd6,
    F3_AND  = 3'd7
  } alu_f3_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/rv_alu_if.sv
// Operand/result bundle between the operand mux (master) and the ALU (slave).
interface rv_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [3:0]       fn;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             out_valid;

  modport master (output in_valid, x, y, fn, input out, zero, out_valid);
  modport slave  (input in_valid, x, y, fn, output out, zero, out_valid);
endinterface

// File: rtl/rv_alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA.
module rv_alu_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   amount,
  input  logic             left,
  input  logic             arith,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    if (left)
      result = operand << amount;
    else if (arith)
      result = $unsigned($signed(operand) >>> amount);
    else
      result = operand >> amount;
  end

endmodule

// File: rtl/rv_alu.sv
// RV32I integer ALU: one-cycle registered result and zero flag, one op per cycle.
module rv_alu
  import rv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  rv_alu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  alu_f3_e          f3;
  logic             alt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sh_res;
  logic [WIDTH-1:0] result;

  assign f3   = alu_f3_e'(bus.fn[2:0]);
  assign alt  = bus.fn[3];
  assign sum  = bus.x + bus.y;
  assign diff = bus.x - bus.y;

  // Only the low SHW bits of y select the shift distance
  rv_alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .operand (bus.x),
    .amount  (bus.y[SHW-1:0]),
    .left    (f3 == F3_SLL),
    .arith   (alt),
    .result  (sh_res)
  );

  always_comb begin
    // NOTE: default first so every path assigns result and no latch is inferred.
    result = '0;
    unique case (f3)
      F3_ADD:  result = alt ? diff : sum;
      F3_SLL,
      F3_SR:   result = sh_res;
      F3_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(bus.x) < $signed(bus.y)};
      F3_SLTU: result = {{(WIDTH-1){1'b0}}, bus.x < bus.y};
      F3_XOR:  result = bus.x ^ bus.y;
      F3_OR:   result = bus.x | bus.y;
      F3_AND:  result = bus.x & bus.y;
      default: result = '0;
    endcase
  end

  // zero tracks the same value loaded into out, so it is reset to 1 alongside out = 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out       <= '0;
      bus.zero      <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out  <= result;
        bus.zero <= (result == '0);
      end
    end
  end

endmodule

// File: tb/tb_rv_alu.sv
// Directed self-checking bench for rv_alu with hand-computed expected values.
module tb_rv_alu;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  rv_alu_if #(.WIDTH(32)) bus ();

  rv_alu #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] exp_out, input logic exp_zero,
                           input logic exp_valid);
    check({tag, ".out"}, bus.out, exp_out);
    check({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, exp_zero});
    check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, exp_valid});
  endtask

  // Present an operation, clock it in, and settle 1 ns after the edge
  task automatic op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.fn       = f;
    bus.x        = a;
    bus.y        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.x        = 32'hDEAD_BEEF;
    bus.y        = 32'h1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.fn       = ALU_ADD;
    bus.x        = 32'd5;
    bus.y        = 32'd7;

    // Reset applied between edges must clear outputs without a clock
    #2 rst = 1'b1;
    #1 check_res("reset_async", 32'h0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 check_res("reset_held", 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check_res("first_add", 32'd12, 1'b0, 1'b1);

    op(ALU_ADD, 32'hFFFF_FFFF, 32'h1);
    check_res("add_wrap", 32'h0, 1'b1, 1'b1);
    op(ALU_SUB, 32'd3, 32'd5);
    check_res("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b1);
    op(ALU_SUB, 32'h1234, 32'h1234);
    check_res("sub_eq", 32'h0, 1'b1, 1'b1);

    op(ALU_SLT, 32'hFFFF_FFFF, 32'h1);
    check_res("slt_neg", 32'h1, 1'b0, 1'b1);
    op(ALU_SLTU, 32'hFFFF_FFFF, 32'h1);
    check_res("sltu_big", 32'h0, 1'b1, 1'b1);
    op(ALU_SLT, 32'd5, 32'd5);
    check_res("slt_equal", 32'h0, 1'b1, 1'b1);
    op(4'hA, 32'hFFFF_FFFF, 32'h1);
    check_res("slt_alt", 32'h1, 1'b0, 1'b1);
    op(4'hB, 32'h1, 32'hFFFF_FFFF);
    check_res("sltu_alt", 32'h1, 1'b0, 1'b1);

    op(ALU_SLL, 32'h1, 32'd31);
    check_res("sll_31", 32'h8000_0000, 1'b0, 1'b1);
    op(ALU_SRL, 32'h8000_0000, 32'd4);
    check_res("srl_4", 32'h0800_0000, 1'b0, 1'b1);
    op(ALU_SRA, 32'h8000_0000, 32'd4);
    check_res("sra_4", 32'hF800_0000, 1'b0, 1'b1);
    op(ALU_SLL, 32'h1, 32'h21);
    check_res("sll_mask", 32'h2, 1'b0, 1'b1);
    op(4'h9, 32'h3, 32'd4);
    check_res("sll_alt", 32'h30, 1'b0, 1'b1);
    op(ALU_SRA, 32'h4000_0000, 32'd20);
    check_res("sra_pos", 32'h0000_0400, 1'b0, 1'b1);

    op(ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check_res("xor", 32'h0FF0_0FF0, 1'b0, 1'b1);
    op(ALU_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check_res("or", 32'hFFF0_FFF0, 1'b0, 1'b1);
    op(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check_res("and", 32'hF000_F000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      check_res($sformatf("hold%0d", i), 32'hF000_F000, 1'b0, 1'b0);
    end

    // Reset mid-flight drops the result just registered
    op(ALU_ADD, 32'd40, 32'd2);
    check_res("pre_reset", 32'd42, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1 check_res("reset_mid", 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    op(ALU_OR, 32'h0, 32'h0);
    check_res("or_zero", 32'h0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
